// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue controller: control codes,
// opcode match patterns and the decoded-instruction record.
package alu_issue_pkg;

  localparam int unsigned OPC_BITS = 11;
  localparam int unsigned CTRL_W   = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b1010;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_ORR  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_EOR  = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_CBZ  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_CBNZ = 4'b1111;
  localparam logic [CTRL_W-1:0] ALU_MOV  = 4'b1101;
  localparam logic [CTRL_W-1:0] ALU_NOP  = 4'b0000;

  // Patterns carry zeros in every don't-care bit of their mask.
  localparam logic [OPC_BITS-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [OPC_BITS-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPC_BITS-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPC_BITS-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [OPC_BITS-1:0] OPC_EOR  = 11'b11001010000;
  localparam logic [OPC_BITS-1:0] OPC_ADDI = 11'b10010001000;
  localparam logic [OPC_BITS-1:0] OPC_SUBI = 11'b11010001000;
  localparam logic [OPC_BITS-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPC_BITS-1:0] OPC_STUR = 11'b11111000000;
  localparam logic [OPC_BITS-1:0] OPC_CBZ  = 11'b10110100000;
  localparam logic [OPC_BITS-1:0] OPC_CBNZ = 11'b10110101000;
  localparam logic [OPC_BITS-1:0] OPC_MOVZ = 11'b11010010100;

  localparam logic [OPC_BITS-1:0] MSK_ALL  = 11'b11111111111;
  localparam logic [OPC_BITS-1:0] MSK_IMM  = 11'b11111111110;
  localparam logic [OPC_BITS-1:0] MSK_CB   = 11'b11111111000;
  localparam logic [OPC_BITS-1:0] MSK_MOVZ = 11'b11111111100;

  typedef enum logic [1:0] {
    SRC_RM   = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_ZERO = 2'd2
  } src2_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    src2_e             src2;
    logic              is_add_sub;
    logic              is_branch;
    logic              illegal;
  } dec_t;

  function automatic logic opc_match(input logic [OPC_BITS-1:0] opc,
                                     input logic [OPC_BITS-1:0] pat,
                                     input logic [OPC_BITS-1:0] msk);
    return (opc & msk) == pat;
  endfunction

endpackage

// File: rtl/alu_opcode_decode.sv
// Combinational LEGv8 opcode decoder: control code, operand-2 source and
// class flags for the issue stage.
module alu_opcode_decode
  import alu_issue_pkg::*;
(
  input  logic [OPC_BITS-1:0] i_opcode,
  output dec_t                o_dec_c
);

  // Unmatched opcodes fall through to the illegal default.
  always_comb begin
    o_dec_c = '{ctrl: ALU_NOP, src2: SRC_ZERO, is_add_sub: 1'b0,
                is_branch: 1'b0, illegal: 1'b1};
    if (opc_match(i_opcode, OPC_ADD, MSK_ALL))
      o_dec_c = '{ALU_ADD, SRC_RM, 1'b1, 1'b0, 1'b0};
    else if (opc_match(i_opcode, OPC_SUB, MSK_ALL))
      o_dec_c = '{ALU_SUB, SRC_RM, 1'b1, 1'b0, 1'b0};
    else if (opc_match(i_opcode, OPC_AND, MSK_ALL))
      o_dec_c = '{ALU_AND, SRC_RM, 1'b0, 1'b0, 1'b0};
    else if (opc_match(i_opcode, OPC_ORR, MSK_ALL))
      o_dec_c = '{ALU_ORR, SRC_RM, 1'b0, 1'b0, 1'b0};
    else if (opc_match(i_opcode, OPC_EOR, MSK_ALL))
      o_dec_c = '{ALU_EOR, SRC_RM, 1'b0, 1'b0, 1'b0};
    else if (opc_match(i_opcode, OPC_ADDI, MSK_IMM))
      o_dec_c = '{ALU_ADD, SRC_IMM, 1'b1, 1'b0, 1'b0};
    else if (opc_match(i_opcode, OPC_SUBI, MSK_IMM))
      o_dec_c = '{ALU_SUB, SRC_IMM, 1'b1, 1'b0, 1'b0};
    else if (opc_match(i_opcode, OPC_LDUR, MSK_ALL) ||
             opc_match(i_opcode, OPC_STUR, MSK_ALL))
      o_dec_c = '{ALU_ADD, SRC_IMM, 1'b0, 1'b0, 1'b0};
    else if (opc_match(i_opcode, OPC_CBZ, MSK_CB))
      o_dec_c = '{ALU_CBZ, SRC_RM, 1'b0, 1'b1, 1'b0};
    else if (opc_match(i_opcode, OPC_CBNZ, MSK_CB))
      o_dec_c = '{ALU_CBNZ, SRC_RM, 1'b0, 1'b1, 1'b0};
    else if (opc_match(i_opcode, OPC_MOVZ, MSK_MOVZ))
      o_dec_c = '{ALU_MOV, SRC_IMM, 1'b0, 1'b0, 1'b0};
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage ALU issue controller: S1 registers decoded operands that drive
// the ALU, S2 captures the ALU result and flags behind a valid/ready port.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OPC_W  = 11
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] rnData,
  input  logic [DATA_W-1:0] rmData,
  input  logic [DATA_W-1:0] immExt,
  output logic [3:0]        aluControl,
  output logic [DATA_W-1:0] aluData1,
  output logic [DATA_W-1:0] aluData2,
  input  logic [DATA_W-1:0] aluResult,
  input  logic              aluOverflow,
  input  logic              aluZero,
  output logic              wbValid,
  input  logic              wbReady,
  output logic [DATA_W-1:0] wbResult,
  output logic              wbOverflow,
  output logic              wbBranch,
  output logic              wbTaken,
  output logic              wbIllegal
);

  dec_t              w_dec;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic              w_s2Adv;
  logic              w_accept;

  logic              r_s1Valid;
  logic [3:0]        r_aluControl;
  logic [DATA_W-1:0] r_aluData1;
  logic [DATA_W-1:0] r_aluData2;
  logic              r_s1AddSub;
  logic              r_s1Branch;
  logic              r_s1Illegal;

  logic              r_wbValid;
  logic [DATA_W-1:0] r_wbResult;
  logic              r_wbOverflow;
  logic              r_wbBranch;
  logic              r_wbTaken;
  logic              r_wbIllegal;

  alu_opcode_decode u_decode (
    .i_opcode (opcode),
    .o_dec_c  (w_dec)
  );

  assign w_s2Adv  = r_s1Valid && (!r_wbValid || wbReady);
  assign inReady  = !r_s1Valid || w_s2Adv;
  assign w_accept = inValid && inReady;

  // Illegal opcodes present all-zero operands to the ALU.
  always_comb begin
    w_op1 = w_dec.illegal ? '0 : rnData;
    case (w_dec.src2)
      SRC_RM:  w_op2 = rmData;
      SRC_IMM: w_op2 = immExt;
      default: w_op2 = '0;
    endcase
  end

  // S1: operands change only on accept so the ALU output is stable while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Valid    <= 1'b0;
      r_aluControl <= ALU_NOP;
      r_aluData1   <= '0;
      r_aluData2   <= '0;
      r_s1AddSub   <= 1'b0;
      r_s1Branch   <= 1'b0;
      r_s1Illegal  <= 1'b0;
    end else if (w_accept) begin
      r_s1Valid    <= 1'b1;
      r_aluControl <= w_dec.ctrl;
      r_aluData1   <= w_op1;
      r_aluData2   <= w_op2;
      r_s1AddSub   <= w_dec.is_add_sub;
      r_s1Branch   <= w_dec.is_branch;
      r_s1Illegal  <= w_dec.illegal;
    end else if (w_s2Adv) begin
      r_s1Valid    <= 1'b0;
    end
  end

  // S2: capture with class-dependent masking of result and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wbValid    <= 1'b0;
      r_wbResult   <= '0;
      r_wbOverflow <= 1'b0;
      r_wbBranch   <= 1'b0;
      r_wbTaken    <= 1'b0;
      r_wbIllegal  <= 1'b0;
    end else if (w_s2Adv) begin
      r_wbValid    <= 1'b1;
      r_wbResult   <= (r_s1Branch || r_s1Illegal) ? '0 : aluResult;
      r_wbOverflow <= r_s1AddSub && aluOverflow;
      r_wbBranch   <= r_s1Branch;
      r_wbTaken    <= r_s1Branch && aluZero;
      r_wbIllegal  <= r_s1Illegal;
    end else if (wbReady) begin
      r_wbValid    <= 1'b0;
    end
  end

  assign aluControl = r_aluControl;
  assign aluData1   = r_aluData1;
  assign aluData2   = r_aluData2;
  assign wbValid    = r_wbValid;
  assign wbResult   = r_wbResult;
  assign wbOverflow = r_wbOverflow;
  assign wbBranch   = r_wbBranch;
  assign wbTaken    = r_wbTaken;
  assign wbIllegal  = r_wbIllegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, vector table with a writeback
// scoreboard, plus hand sequences for branches, stalls and async reset.
module tb_alu_issue_ctrl;

  typedef struct {
    logic [10:0] op;
    logic [31:0] rn, rm, imm;
    logic [3:0]  ctrl;
    logic [31:0] d1, d2, res;
    logic        ovf, br, tk, ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf, br, tk, ill;
  } exp_t;

  logic        clk, reset_n, inValid, inReady;
  logic [10:0] opcode;
  logic [31:0] rnData, rmData, immExt, aluData1, aluData2, aluResult, wbResult;
  logic [3:0]  aluControl;
  logic        aluOverflow, aluZero, wbValid, wbReady;
  logic        wbOverflow, wbBranch, wbTaken, wbIllegal;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb[$];
  vec_t tv[18];

  alu_issue_ctrl #(.DATA_W(32), .OPC_W(11)) dut (
    .clk(clk), .reset_n(reset_n), .inValid(inValid), .inReady(inReady),
    .opcode(opcode), .rnData(rnData), .rmData(rmData), .immExt(immExt),
    .aluControl(aluControl), .aluData1(aluData1), .aluData2(aluData2),
    .aluResult(aluResult), .aluOverflow(aluOverflow), .aluZero(aluZero),
    .wbValid(wbValid), .wbReady(wbReady), .wbResult(wbResult),
    .wbOverflow(wbOverflow), .wbBranch(wbBranch), .wbTaken(wbTaken),
    .wbIllegal(wbIllegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; overflow is deliberately 1 for non-arithmetic codes
  // so the controller's masking is observable.
  always_comb begin
    aluResult   = 32'hDEAD_BEEF;
    aluOverflow = 1'b1;
    case (aluControl)
      4'b0010: begin
        aluResult   = aluData1 + aluData2;
        aluOverflow = (aluData1[31] == aluData2[31]) && (aluResult[31] != aluData1[31]);
      end
      4'b1010: begin
        aluResult   = aluData1 - aluData2;
        aluOverflow = (aluData1[31] != aluData2[31]) && (aluResult[31] != aluData1[31]);
      end
      4'b0110: aluResult = aluData1 & aluData2;
      4'b0100: aluResult = aluData1 | aluData2;
      4'b1001: aluResult = aluData1 ^ aluData2;
      4'b0111, 4'b1111, 4'b1101: aluResult = aluData2;
      default: ;
    endcase
    aluZero = (aluControl == 4'b1111) ? (aluData2 != 32'd0) : (aluResult == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one instruction, wait (bounded) for accept, push its expectation.
  task automatic issue(input vec_t v);
    logic ok;
    opcode = v.op; rnData = v.rn; rmData = v.rm; immExt = v.imm;
    inValid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (inReady) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      inValid = 1'b0;
      return;
    end
    sb.push_back('{v.res, v.ovf, v.br, v.tk, v.ill});
    @(posedge clk); #1;
    inValid = 1'b0;
    chk("aluControl", 32'(aluControl), 32'(v.ctrl));
    chk("aluData1", aluData1, v.d1);
    chk("aluData2", aluData2, v.d2);
  endtask

  task automatic drain();
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: one transfer per cycle where wbValid && wbReady.
  always @(negedge clk) begin
    if (reset_n && wbValid && wbReady) begin
      if (sb.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wbResult", wbResult, e.res);
        chk("wbOverflow", 32'(wbOverflow), 32'(e.ovf));
        chk("wbBranch", 32'(wbBranch), 32'(e.br));
        chk("wbTaken", 32'(wbTaken), 32'(e.tk));
        chk("wbIllegal", 32'(wbIllegal), 32'(e.ill));
      end
    end
  end

  initial begin
    vec_t v;
    tv[0]  = '{11'b11001011000, 32'd9, 32'd4, 32'd0, 4'hA, 32'd9, 32'd4, 32'd5, 0, 0, 0, 0};
    tv[1]  = '{11'b10001010000, 32'hF0F0, 32'hFF00, 32'd0, 4'h6, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0, 0};
    tv[2]  = '{11'b10101010000, 32'hF0, 32'h0F, 32'd0, 4'h4, 32'hF0, 32'h0F, 32'hFF, 0, 0, 0, 0};
    tv[3]  = '{11'b11001010000, 32'hFF, 32'h0F, 32'd0, 4'h9, 32'hFF, 32'h0F, 32'hF0, 0, 0, 0, 0};
    tv[4]  = '{11'b10010001001, 32'd10, 32'd77, 32'd3, 4'h2, 32'd10, 32'd3, 32'd13, 0, 0, 0, 0};
    tv[5]  = '{11'b11010001000, 32'd10, 32'd77, 32'd4, 4'hA, 32'd10, 32'd4, 32'd6, 0, 0, 0, 0};
    tv[6]  = '{11'b11111000010, 32'h7FFFFFFF, 32'd0, 32'd1, 4'h2, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 0, 0, 0};
    tv[7]  = '{11'b11111000000, 32'd100, 32'd5, 32'd8, 4'h2, 32'd100, 32'd8, 32'd108, 0, 0, 0, 0};
    tv[8]  = '{11'b10110100111, 32'd3, 32'd5, 32'd0, 4'h7, 32'd3, 32'd5, 32'd0, 0, 1, 0, 0};
    tv[9]  = '{11'b10110101000, 32'd3, 32'd5, 32'd0, 4'hF, 32'd3, 32'd5, 32'd0, 0, 1, 1, 0};
    tv[10] = '{11'b11010010110, 32'd1, 32'd9, 32'h1234, 4'hD, 32'd1, 32'h1234, 32'h1234, 0, 0, 0, 0};
    tv[11] = '{11'b00000000000, 32'd5, 32'd6, 32'd7, 4'h0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1};
    tv[12] = '{11'b11001011000, 32'd9, 32'd4, 32'd0, 4'hA, 32'd9, 32'd4, 32'd5, 0, 0, 0, 0};
    tv[13] = '{11'b11001011000, 32'h80000000, 32'd1, 32'd0, 4'hA, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1, 0, 0, 0};
    tv[14] = '{11'b10001010000, 32'h80000000, 32'd1, 32'd0, 4'h6, 32'h80000000, 32'd1, 32'd0, 0, 0, 0, 0};
    tv[15] = '{11'b10001011000, 32'h7FFFFFFF, 32'd1, 32'd0, 4'h2, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 0, 0, 0};
    tv[16] = '{11'b10001011001, 32'd5, 32'd6, 32'd0, 4'h0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1};
    tv[17] = '{11'b10010001010, 32'd5, 32'd6, 32'd2, 4'h0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1};

    reset_n = 1'b1; inValid = 1'b0; wbReady = 1'b1;
    opcode = '0; rnData = '0; rmData = '0; immExt = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wbValid", 32'(wbValid), 32'd0);
    chk("rst_aluControl", 32'(aluControl), 32'd0);
    chk("rst_aluData1", aluData1, 32'd0);
    chk("rst_aluData2", aluData2, 32'd0);
    chk("rst_wbResult", wbResult, 32'd0);
    chk("rst_inReady", 32'(inReady), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // ADD 5+7: two-edge latency.
    v = '{11'b10001011000, 32'd5, 32'd7, 32'd0, 4'h2, 32'd5, 32'd7, 32'd12, 0, 0, 0, 0};
    issue(v);
    chk("lat_wbValid_n1", 32'(wbValid), 32'd0);
    @(posedge clk); #1;
    chk("lat_wbValid_n2", 32'(wbValid), 32'd1);
    chk("lat_wbResult", wbResult, 32'd12);
    drain();

    // CBZ then CBNZ with rm=0, back to back.
    v = '{11'b10110100000, 32'd1, 32'd0, 32'd0, 4'h7, 32'd1, 32'd0, 32'd0, 0, 1, 1, 0};
    issue(v);
    v = '{11'b10110101000, 32'd1, 32'd0, 32'd0, 4'hF, 32'd1, 32'd0, 32'd0, 0, 1, 0, 0};
    issue(v);
    chk("cb_first_valid", 32'(wbValid), 32'd1);
    chk("cb_first_taken", 32'(wbTaken), 32'd1);
    @(posedge clk); #1;
    chk("cb_second_valid", 32'(wbValid), 32'd1);
    chk("cb_second_taken", 32'(wbTaken), 32'd0);
    drain();

    for (int i = 0; i < 18; i++) issue(tv[i]);
    drain();

    // Three ADDI under a 4-cycle downstream stall.
    wbReady = 1'b0;
    fork
      begin
        for (int k = 1; k <= 3; k++) begin
          vec_t a;
          a = '{11'b10010001000, 32'd10, 32'd0, 32'(k), 4'h2, 32'd10, 32'(k), 32'(10 + k), 0, 0, 0, 0};
          issue(a);
        end
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_inReady_a", 32'(inReady), 32'd0);
        chk("stall_wbResult_a", wbResult, 32'd11);
        @(negedge clk);
        chk("stall_inReady_b", 32'(inReady), 32'd0);
        chk("stall_wbValid_b", 32'(wbValid), 32'd1);
        chk("stall_wbResult_b", wbResult, 32'd11);
        @(posedge clk); #1;
        wbReady = 1'b1;
      end
    join
    drain();

    // Async reset with both stages full.
    wbReady = 1'b0;
    v = '{11'b10001011000, 32'd1, 32'd1, 32'd0, 4'h2, 32'd1, 32'd1, 32'd2, 0, 0, 0, 0};
    issue(v);
    v = '{11'b10001011000, 32'd2, 32'd2, 32'd0, 4'h2, 32'd2, 32'd2, 32'd4, 0, 0, 0, 0};
    issue(v);
    chk("full_wbValid", 32'(wbValid), 32'd1);
    chk("full_inReady", 32'(inReady), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_wbValid", 32'(wbValid), 32'd0);
    chk("arst_aluControl", 32'(aluControl), 32'd0);
    chk("arst_wbResult", wbResult, 32'd0);
    chk("arst_aluData1", aluData1, 32'd0);
    sb.delete();
    @(negedge clk) reset_n = 1'b1;
    wbReady = 1'b1;
    @(posedge clk); #1;
    v = '{11'b10001011000, 32'd5, 32'd7, 32'd0, 4'h2, 32'd5, 32'd7, 32'd12, 0, 0, 0, 0};
    issue(v);
    chk("post_rst_n1", 32'(wbValid), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_n2", 32'(wbValid), 32'd1);
    chk("post_rst_res", wbResult, 32'd12);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream driver for the datapath ALU. Accepts one decoded LEGv8 instruction per cycle on a valid/ready handshake and translates its 11-bit opcode into the 4-bit ALU control code.
- Selects and registers the ALU operands, then captures the ALU's result and flags one cycle later into a writeback register. The writeback register has its own valid/ready handshake.
- Sits between the instruction decode/register-read stage and the ALU/writeback stage.

Parameters:
- DATA_W, 32, width of operands, immediate and result.
- OPC_W, 11, width of the instruction opcode field.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- inValid  in  1  upstream instruction valid
- inReady  out  1  block can accept an instruction this cycle
- opcode  in  OPC_W  instruction bits [31:21]
- rnData  in  DATA_W  first source register value
- rmData  in  DATA_W  second source register value (Rm, or Rt for CBZ/CBNZ/STUR)
- immExt  in  DATA_W  sign/zero-extended immediate from decode
- aluControl  out  4  control code to ALU
- aluData1  out  DATA_W  ALU operand 1
- aluData2  out  DATA_W  ALU operand 2
- aluResult  in  DATA_W  ALU result (combinational from aluData*)
- aluOverflow  in  1  ALU carry/overflow bit
- aluZero  in  1  ALU zero flag
- wbValid  out  1  writeback register holds a result
- wbReady  in  1  downstream consumes the result
- wbResult  out  DATA_W  captured result
- wbOverflow  out  1  captured overflow (ADD/SUB/ADDI/SUBI only, else 0)
- wbBranch  out  1  captured instruction was CBZ/CBNZ
- wbTaken  out  1  branch condition met (valid only when wbBranch=1)
- wbIllegal  out  1  opcode not recognised

Behaviour:
- Reset (async, reset_n=0): both stage valids 0, aluControl=4'b0000, aluData1/2=0, all wb* outputs 0. Reset mid-operation discards in-flight instructions. Nothing is replayed.
- Stage pipeline: S1 is the issue register that drives the ALU; S2 is the writeback register.
  - s2Adv = s1Valid && (!wbValid || wbReady).
  - inReady = !s1Valid || s2Adv.
  - Accept occurs when inValid && inReady.
- Latency: accepted at edge N; wbValid=1 after edge N+1. Throughput is 1 instruction/cycle while wbReady=1.
- Stall: when wbValid && !wbReady, S2 holds all wb* outputs stable and S1 holds. inReady=0 whenever S1 is also full.
- Decode at accept (opcode → aluControl, aluData2 source):
  - ADD 10001011000 → 0010, rm
  - SUB 11001011000 → 1010, rm
  - AND 10001010000 → 0110, rm
  - ORR 10101010000 → 0100, rm
  - EOR 11001010000 → 1001, rm
  - ADDI 1001000100x → 0010, imm
  - SUBI 1101000100x → 1010, imm
  - LDUR 11111000010 and STUR 11111000000 → 0010, imm
  - CBZ 10110100xxx → 0111, rm
  - CBNZ 10110101xxx → 1111, rm
  - MOVZ 110100101xx → 1101, imm
- aluData1 = rnData for all recognised opcodes.
- Unrecognised opcode: aluControl=4'b0000, operands 0. The S2 capture forces wbResult=0, wbIllegal=1, wbOverflow=0, wbBranch=0. The pipeline continues and does not stall.
- S2 capture on s2Adv:
  - wbResult=aluResult for non-branch ops; 0 for branches.
  - wbOverflow=aluOverflow only for add/sub class.
  - wbBranch=1 for CBZ/CBNZ; wbTaken=aluZero for branches, else 0.
- Simultaneous accept and S2 advance in the same cycle is legal and required, giving back-to-back flow with no bubble.
- aluControl/aluData1/aluData2 change only on accept. They hold across stalls so the combinational ALU output stays stable.

Decomposition:
- Package alu_issue_pkg holds:
  - the ALU control code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_CBZ, ALU_CBNZ, ALU_MOV, ALU_NOP);
  - the opcode match constants/masks;
  - an enum for operand-2 source (SRC_RM, SRC_IMM, SRC_ZERO).
- One sub-module is natural: alu_opcode_decode. It is combinational: opcode → {aluControl, src2Sel, isAddSub, isBranch, illegal}.

Test Plan:
- ADD, rn=5, rm=7, wbReady=1 → aluControl=0010, aluData2=7; wbValid after 2 edges, wbResult=12, wbOverflow=0.
- CBZ with rm=0, then CBNZ with rm=0, back-to-back → wbBranch=1 both; wbTaken=1 then 0; wbResult=0; no bubble between them.
- Three ADDI (imm=1,2,3, rn=10) with wbReady held 0 for 4 cycles → inReady drops after 2 accepts; wbResult holds 11. Releasing wbReady yields 11, 12, 13 in order, none lost.
- Opcode 00000000000 → wbIllegal=1, wbResult=0; the following SUB 9-4 → wbResult=5, wbIllegal=0.
- SUB 0x80000000 - 1 → wbOverflow=aluOverflow from ALU; then AND of the same operands → wbOverflow=0.
- Assert reset_n=0 asynchronously with S1 and S2 full → wbValid, aluControl and wbResult go to 0 immediately without a clock edge; the first instruction after release has the normal 2-edge latency.
